// File: rtl/id_ex_pipe.sv
// ID->EX pipeline register: valid/ready handshake, optional 2-entry skid buffer,
// synchronous flush, bubble-gated control outputs and a saturating stall counter.
module id_ex_pipe #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned REG_W   = 5,
  parameter int unsigned WB_W    = 2,
  parameter int unsigned M_W     = 3,
  parameter int unsigned ALUOP_W = 2,
  parameter int unsigned SKID    = 1,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WB_W-1:0]      ctlwb_out,
  input  logic [M_W-1:0]       ctlm_out,
  input  logic [ALUOP_W+1:0]   ctlex_out,
  input  logic [DATA_W-1:0]    npc,
  input  logic [DATA_W-1:0]    readdat1,
  input  logic [DATA_W-1:0]    readdat2,
  input  logic [DATA_W-1:0]    signext_out,
  input  logic [REG_W-1:0]     instr_2016,
  input  logic [REG_W-1:0]     instr_1511,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WB_W-1:0]      wb_ctlout,
  output logic [M_W-1:0]       m_ctlout,
  output logic                 regdst,
  output logic [ALUOP_W-1:0]   aluop,
  output logic                 alusrc,
  output logic [DATA_W-1:0]    npcout,
  output logic [DATA_W-1:0]    rdata1out,
  output logic [DATA_W-1:0]    rdata2out,
  output logic [DATA_W-1:0]    s_extendout,
  output logic [REG_W-1:0]     instrout_2016,
  output logic [REG_W-1:0]     instrout_1511,
  output logic [CNT_W-1:0]     stall_cnt
);

  localparam int unsigned EX_W  = ALUOP_W + 2;
  localparam int unsigned CTL_W = WB_W + M_W + EX_W;
  localparam int unsigned DAT_W = 4 * DATA_W + 2 * REG_W;

  logic [CTL_W-1:0] w_in_ctl;
  logic [DAT_W-1:0] w_in_dat;
  logic             w_accept;
  logic             w_consume;

  logic             r_a_valid;
  logic [CTL_W-1:0] r_a_ctl;
  logic [DAT_W-1:0] r_a_dat;
  logic             r_b_valid;
  logic [CTL_W-1:0] r_b_ctl;
  logic [DAT_W-1:0] r_b_dat;
  logic [CNT_W-1:0] r_stall;

  assign w_in_ctl = {ctlwb_out, ctlm_out, ctlex_out};
  assign w_in_dat = {npc, readdat1, readdat2, signext_out, instr_2016, instr_1511};

  // Skid variant registers in_ready from B occupancy; single-entry variant passes ready through.
  generate
    if (SKID != 0) begin : g_skid
      assign in_ready = ~r_b_valid;
    end else begin : g_noskid
      assign in_ready = ~r_a_valid | out_ready;
    end
  endgenerate

  assign w_accept  = in_valid & in_ready;
  assign w_consume = r_a_valid & out_ready;

  // Slot A drives the outputs; control bits are zeroed whenever A is empty so bubbles read 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a_valid <= 1'b0;
      r_a_ctl   <= '0;
      r_a_dat   <= '0;
      r_b_valid <= 1'b0;
      r_b_ctl   <= '0;
      r_b_dat   <= '0;
    end else if (flush) begin
      r_a_valid <= 1'b0;
      r_a_ctl   <= '0;
      r_b_valid <= 1'b0;
    end else if (!r_a_valid) begin
      if (w_accept) begin
        r_a_valid <= 1'b1;
        r_a_ctl   <= w_in_ctl;
        r_a_dat   <= w_in_dat;
      end
    end else if (w_consume) begin
      if (r_b_valid) begin
        r_a_ctl <= r_b_ctl;
        r_a_dat <= r_b_dat;
        if (w_accept) begin
          r_b_ctl <= w_in_ctl;
          r_b_dat <= w_in_dat;
        end else begin
          r_b_valid <= 1'b0;
        end
      end else if (w_accept) begin
        r_a_ctl <= w_in_ctl;
        r_a_dat <= w_in_dat;
      end else begin
        r_a_valid <= 1'b0;
        r_a_ctl   <= '0;
      end
    end else if (w_accept) begin
      r_b_valid <= 1'b1;
      r_b_ctl   <= w_in_ctl;
      r_b_dat   <= w_in_dat;
    end
  end

  // Back-pressure counter: saturates at all-ones, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall <= '0;
    end else if (r_a_valid && !out_ready && (r_stall != {CNT_W{1'b1}})) begin
      r_stall <= r_stall + CNT_W'(1);
    end
  end

  assign out_valid = r_a_valid;
  assign {wb_ctlout, m_ctlout, regdst, aluop, alusrc} = r_a_ctl;
  assign {npcout, rdata1out, rdata2out, s_extendout, instrout_2016, instrout_1511} = r_a_dat;
  assign stall_cnt = r_stall;

endmodule
